// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: operation codes, FSM state
// encoding, shifter direction and small decode helpers.
package alu_pkg;

   typedef logic [4:0] aluc_t;

   localparam aluc_t ALU_ADD  = 5'd0;
   localparam aluc_t ALU_SUB  = 5'd1;
   localparam aluc_t ALU_AND  = 5'd2;
   localparam aluc_t ALU_OR   = 5'd3;
   localparam aluc_t ALU_XOR  = 5'd4;
   localparam aluc_t ALU_SLT  = 5'd5;
   localparam aluc_t ALU_SLL  = 5'd6;
   localparam aluc_t ALU_SLLV = 5'd7;
   localparam aluc_t ALU_SRA  = 5'd8;
   localparam aluc_t ALU_SRAV = 5'd9;
   localparam aluc_t ALU_SRL  = 5'd10;
   localparam aluc_t ALU_SRLV = 5'd11;
   localparam aluc_t ALU_LUI  = 5'd13;
   localparam aluc_t ALU_NOR  = 5'd14;

   // Execute-stage FSM encoding (kept as plain constants for legacy tools)
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;

   typedef enum logic [1:0] {
      SH_LEFT = 2'd0,
      SH_SRL  = 2'd1,
      SH_SRA  = 2'd2
   } shift_kind_t;

   // True for every shift opcode, immediate or variable amount
   function automatic logic is_shift(input aluc_t code);
      logic r;
      case (code)
         ALU_SLL, ALU_SLLV, ALU_SRA, ALU_SRAV, ALU_SRL, ALU_SRLV: r = 1'b1;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   // Variable shifts take their amount from a[4:0] instead of shamt
   function automatic logic uses_var_amt(input aluc_t code);
      logic r;
      case (code)
         ALU_SLLV, ALU_SRAV, ALU_SRLV: r = 1'b1;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   // Direction/fill of a shift opcode (left for non-shift codes, unused there)
   function automatic shift_kind_t shift_kind(input aluc_t code);
      shift_kind_t k;
      case (code)
         ALU_SRA, ALU_SRAV: k = SH_SRA;
         ALU_SRL, ALU_SRLV: k = SH_SRL;
         default:           k = SH_LEFT;
      endcase
      return k;
   endfunction

endpackage

// File: rtl/alu_exec_if.sv
// Handshake bus between ID/EX (master side) and the execute-stage ALU
// (slave side), including the result channel toward MEM.
interface alu_exec_if #(parameter int WIDTH = 32);

   logic             in_valid;
   logic             in_ready;
   logic [4:0]       aluc;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [4:0]       shamt;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             overflow;

   modport master (
      output in_valid, aluc, a, b, shamt, out_ready,
      input  in_ready, out_valid, result, zero, overflow
   );

   modport slave (
      input  in_valid, aluc, a, b, shamt, out_ready,
      output in_ready, out_valid, result, zero, overflow
   );

endinterface

// File: rtl/alu_shifter.sv
// Shift engine for the execute-stage ALU.
// Default build: iterative 1-bit-per-cycle shifter with work register,
// countdown and a done pulse on the last step.
// With ALU_BARREL_SHIFT_EN defined: combinational barrel shifter; the
// iterative path is never started and done stays low.
module alu_shifter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  shift_kind_t      kind,
   input  logic [WIDTH-1:0] value,
   input  logic [4:0]       amt,
   output logic [WIDTH-1:0] imm_result,
   output logic [WIDTH-1:0] final_result,
   output logic             done
);

`ifdef ALU_BARREL_SHIFT_EN

   logic unused_sink_s;
   assign unused_sink_s = ^{clk, rst, start};

   // Single-cycle barrel shift of the operand
   always_comb begin
      imm_result = value;
      case (kind)
         SH_LEFT: imm_result = value << amt;
         SH_SRL:  imm_result = value >> amt;
         SH_SRA:  imm_result = WIDTH'($signed(value) >>> amt);
         default: imm_result = value;
      endcase
   end

   assign final_result = value;
   assign done         = 1'b0;

`else

   logic [WIDTH-1:0] work_r;
   logic [4:0]       cnt_r;
   shift_kind_t      kind_r;
   logic [WIDTH-1:0] step_s;

   // A zero-amount shift is just the operand, produced in one cycle
   assign imm_result = value;

   // One-bit step of the work register in the captured direction
   always_comb begin
      step_s = work_r;
      case (kind_r)
         SH_LEFT: step_s = {work_r[WIDTH-2:0], 1'b0};
         SH_SRL:  step_s = {1'b0, work_r[WIDTH-1:1]};
         SH_SRA:  step_s = {work_r[WIDTH-1], work_r[WIDTH-1:1]};
         default: step_s = work_r;
      endcase
   end

   // Load on start, then step and count down until the count is exhausted
   always_ff @(posedge clk) begin
      if (rst) begin
         work_r <= {WIDTH{1'b0}};
         cnt_r  <= 5'd0;
         kind_r <= SH_LEFT;
      end else if (start) begin
         work_r <= value;
         cnt_r  <= amt;
         kind_r <= kind;
      end else if (cnt_r != 5'd0) begin
         work_r <= step_s;
         cnt_r  <= cnt_r - 5'd1;
      end else begin
         work_r <= work_r;
         cnt_r  <= cnt_r;
      end
   end

   // The step taken while the count reads 1 is the final one
   assign final_result = step_s;
   assign done         = (cnt_r == 5'd1);

`endif

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU with registered result and valid/ready handshake.
// Non-shift ops (and zero-amount shifts) complete in one cycle; shifts use
// alu_shifter and stall ID/EX through in_ready while iterating.
// Optional macro ALU_BARREL_SHIFT_EN: all shifts complete in one cycle.
module alu_exec
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input logic       clk,
   input logic       rst,
   alu_exec_if.slave bus
);

   logic [0:0]       state_r;
   logic             out_valid_r;
   logic [WIDTH-1:0] result_r;
   logic             zero_r;
   logic             overflow_r;

   logic             accept_s;
   logic             start_s;
   logic [4:0]       amt_s;
   shift_kind_t      kind_s;
   logic [WIDTH-1:0] sum_s;
   logic [WIDTH-1:0] diff_s;
   logic [WIDTH-1:0] single_res_s;
   logic             single_ovf_s;
   logic [WIDTH-1:0] sh_imm_s;
   logic [WIDTH-1:0] sh_final_s;
   logic             sh_done_s;

   assign bus.in_ready  = (state_r == ST_IDLE) && (!out_valid_r || bus.out_ready);
   assign bus.out_valid = out_valid_r;
   assign bus.result    = result_r;
   assign bus.zero      = zero_r;
   assign bus.overflow  = overflow_r;

   assign accept_s = bus.in_valid && bus.in_ready;
   assign amt_s    = uses_var_amt(bus.aluc) ? bus.a[4:0] : bus.shamt;
   assign kind_s   = shift_kind(bus.aluc);
   assign sum_s    = bus.a + bus.b;
   assign diff_s   = bus.a - bus.b;

`ifdef ALU_BARREL_SHIFT_EN
   assign start_s = 1'b0;
`else
   assign start_s = accept_s && is_shift(bus.aluc) && (amt_s != 5'd0);
`endif

   alu_shifter #(.WIDTH(WIDTH)) u_shifter (
      .clk          (clk),
      .rst          (rst),
      .start        (start_s),
      .kind         (kind_s),
      .value        (bus.b),
      .amt          (amt_s),
      .imm_result   (sh_imm_s),
      .final_result (sh_final_s),
      .done         (sh_done_s)
   );

   // Single-cycle result and overflow for the presented opcode
   always_comb begin
      single_res_s = sum_s;
      single_ovf_s = 1'b0;
      case (bus.aluc)
         ALU_ADD: begin
            single_res_s = sum_s;
            single_ovf_s = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                           (sum_s[WIDTH-1] != bus.a[WIDTH-1]);
         end
         ALU_SUB: begin
            single_res_s = diff_s;
            single_ovf_s = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                           (diff_s[WIDTH-1] != bus.a[WIDTH-1]);
         end
         ALU_AND: single_res_s = bus.a & bus.b;
         ALU_OR:  single_res_s = bus.a | bus.b;
         ALU_XOR: single_res_s = bus.a ^ bus.b;
         ALU_NOR: single_res_s = ~(bus.a | bus.b);
         ALU_SLT: single_res_s = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
         ALU_SLL, ALU_SLLV, ALU_SRA, ALU_SRAV, ALU_SRL, ALU_SRLV:
            single_res_s = sh_imm_s;
         ALU_LUI: single_res_s = {bus.b[15:0], 16'h0000};
         default: begin
            // Reserved codes behave as add without the overflow flag
            single_res_s = sum_s;
            single_ovf_s = 1'b0;
         end
      endcase
   end

   // Sequencing between accepting ops and waiting on the iterative shifter
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE:  state_r <= start_s ? ST_SHIFT : ST_IDLE;
            ST_SHIFT: state_r <= sh_done_s ? ST_IDLE : ST_SHIFT;
            default:  state_r <= ST_IDLE;
         endcase
      end
   end

   // Result register: load on completion, hold under backpressure
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         result_r    <= {WIDTH{1'b0}};
         zero_r      <= 1'b1;
         overflow_r  <= 1'b0;
      end else if (accept_s && !start_s) begin
         out_valid_r <= 1'b1;
         result_r    <= single_res_s;
         zero_r      <= (single_res_s == {WIDTH{1'b0}});
         overflow_r  <= single_ovf_s;
      end else if (sh_done_s && (state_r == ST_SHIFT)) begin
         out_valid_r <= 1'b1;
         result_r    <= sh_final_s;
         zero_r      <= (sh_final_s == {WIDTH{1'b0}});
         overflow_r  <= 1'b0;
      end else if (bus.out_ready) begin
         out_valid_r <= 1'b0;
      end else begin
         out_valid_r <= out_valid_r;
      end
   end

endmodule

// File: tb/tb_alu_exec.sv
// Directed, table-driven bench for alu_exec plus hand-written sequences for
// backpressure and reset during an iterative shift.
module tb_alu_exec;
   import alu_pkg::*;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_fail;

   alu_exec_if #(.WIDTH(32)) bus ();

   alu_exec #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  aluc;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  shamt;
      logic [31:0] res;
      logic        ovf;
   } vec_t;

   vec_t vt [0:18];

   function automatic vec_t mk(input logic [4:0] c, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] s,
                               input logic [31:0] r, input logic o);
      vec_t v;
      v.aluc = c; v.a = a; v.b = b; v.shamt = s; v.res = r; v.ovf = o;
      return v;
   endfunction

   // Expected accept-to-valid latency in cycles
   function automatic int exp_lat(input vec_t v);
      int n;
      if (!is_shift(v.aluc)) return 1;
`ifdef ALU_BARREL_SHIFT_EN
      return 1;
`else
      n = uses_var_amt(v.aluc) ? int'(v.a[4:0]) : int'(v.shamt);
      return (n == 0) ? 1 : n + 1;
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic apply(input int idx);
      vec_t v;
      int   lat;
      int   low;
      v = vt[idx];
      @(negedge clk);
      bus.aluc = v.aluc; bus.a = v.a; bus.b = v.b; bus.shamt = v.shamt;
      bus.in_valid = 1'b1;
      #1;
      check($sformatf("v%0d in_ready", idx), 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      lat = 1;
      low = 0;
      @(negedge clk);
      while (!bus.out_valid && lat < 100) begin
         if (!bus.in_ready) low++;
         @(negedge clk);
         lat++;
      end
      check($sformatf("v%0d result", idx), bus.result, v.res);
      check($sformatf("v%0d zero", idx), 32'(bus.zero), 32'(v.res == 32'd0));
      check($sformatf("v%0d overflow", idx), 32'(bus.overflow), 32'(v.ovf));
      check($sformatf("v%0d latency", idx), 32'(lat), 32'(exp_lat(v)));
      check($sformatf("v%0d stall cycles", idx), 32'(low), 32'(exp_lat(v) - 1));
   endtask

   initial begin
      int bad;
      n_vec  = 0;
      n_fail = 0;

      vt[0]  = mk(ALU_ADD,  32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 1'b1);
      vt[1]  = mk(ALU_SUB,  32'h00000005, 32'h00000005, 5'd0,  32'h00000000, 1'b0);
      vt[2]  = mk(ALU_SLT,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000001, 1'b0);
      vt[3]  = mk(ALU_LUI,  32'h00000000, 32'h0000ABCD, 5'd0,  32'hABCD0000, 1'b0);
      vt[4]  = mk(ALU_NOR,  32'h00000000, 32'h00000000, 5'd0,  32'hFFFFFFFF, 1'b0);
      vt[5]  = mk(ALU_AND,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hF000F000, 1'b0);
      vt[6]  = mk(ALU_OR,   32'h0F0F0000, 32'h000000F0, 5'd0,  32'h0F0F00F0, 1'b0);
      vt[7]  = mk(ALU_XOR,  32'hFFFF0000, 32'hFF00FF00, 5'd0,  32'h00FFFF00, 1'b0);
      vt[8]  = mk(ALU_SUB,  32'h80000000, 32'h00000001, 5'd0,  32'h7FFFFFFF, 1'b1);
      vt[9]  = mk(ALU_ADD,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 1'b0);
      vt[10] = mk(ALU_SLT,  32'h00000001, 32'hFFFFFFFF, 5'd0,  32'h00000000, 1'b0);
      vt[11] = mk(5'd12,    32'h00000003, 32'h00000004, 5'd0,  32'h00000007, 1'b0);
      vt[12] = mk(5'd31,    32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 1'b0);
      vt[13] = mk(ALU_SRA,  32'h00000000, 32'h80000000, 5'd4,  32'hF8000000, 1'b0);
      vt[14] = mk(ALU_SRLV, 32'h0000001F, 32'h80000000, 5'd0,  32'h00000001, 1'b0);
      vt[15] = mk(ALU_SLL,  32'h00000000, 32'h00001234, 5'd0,  32'h00001234, 1'b0);
      vt[16] = mk(ALU_SRAV, 32'h00000008, 32'hF0000000, 5'd0,  32'hFFF00000, 1'b0);
      vt[17] = mk(ALU_SLLV, 32'h00000024, 32'h00000001, 5'd9,  32'h00000010, 1'b0);
      vt[18] = mk(ALU_SRL,  32'h00000000, 32'h80000000, 5'd31, 32'h00000001, 1'b0);

      rst = 1'b1;
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      bus.aluc = 5'd0; bus.a = 32'd0; bus.b = 32'd0; bus.shamt = 5'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset out_valid", 32'(bus.out_valid), 32'd0);
      check("reset result", bus.result, 32'd0);
      check("reset zero", 32'(bus.zero), 32'd1);
      check("reset overflow", 32'(bus.overflow), 32'd0);
      check("reset in_ready", 32'(bus.in_ready), 32'd1);
      rst = 1'b0;

      for (int i = 0; i <= 18; i++) apply(i);

      // Backpressure: result held three cycles, then back-to-back accept
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.aluc = ALU_ADD; bus.a = 32'd1; bus.b = 32'd2; bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.aluc = ALU_XOR; bus.a = 32'h0000FFFF; bus.b = 32'h00FF00FF;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("bp hold valid %0d", k), 32'(bus.out_valid), 32'd1);
         check($sformatf("bp hold result %0d", k), bus.result, 32'h00000003);
         check($sformatf("bp in_ready %0d", k), 32'(bus.in_ready), 32'd0);
      end
      bus.out_ready = 1'b1;
      #1 check("bp release in_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      @(negedge clk);
      check("bp next valid", 32'(bus.out_valid), 32'd1);
      check("bp next result", bus.result, 32'h00FFFF00);
      @(negedge clk);
      check("bp no duplicate", 32'(bus.out_valid), 32'd0);

      // Reset during the third cycle of a 10-bit sll aborts the op
      @(negedge clk);
      bus.aluc = ALU_SLL; bus.b = 32'h00000001; bus.shamt = 5'd10; bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("abort out_valid", 32'(bus.out_valid), 32'd0);
      check("abort in_ready", 32'(bus.in_ready), 32'd1);
      check("abort result", bus.result, 32'd0);
      bad = 0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         if (bus.out_valid) bad++;
      end
      check("abort no late result", 32'(bad), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
